mem_port_arbiter: RTL and testbench

//   Shares one single-port unified memory (memoria-style: 64-bit word, 6-bit

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports
// with a fixed-latency IDLE/ACCESS/RESP handshake and tie-break fairness.
module mem_port_arbiter #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 64,
   parameter int INSTR_W = 32,
   parameter int MEM_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_req,
   input  logic [ADDR_W-1:0]  if_addr,
   output logic               if_ready,
   output logic [INSTR_W-1:0] if_rdata,
   input  logic               dm_req,
   input  logic               dm_we,
   input  logic [ADDR_W-1:0]  dm_addr,
   input  logic [DATA_W-1:0]  dm_wdata,
   output logic               dm_ready,
   output logic [DATA_W-1:0]  dm_rdata,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               stall_if
);
   localparam int CNT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dm_q, dm_d, last_dm_q, last_dm_d, we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d, dm_rdata_q, dm_rdata_d;
   logic [INSTR_W-1:0] if_rdata_q, if_rdata_d;
   logic               last_acc;
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dm_d       = dm_q;
      last_dm_d  = last_dm_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      dm_rdata_d = dm_rdata_q;
      if_rdata_d = if_rdata_q;
      last_acc   = state_q == ACCESS && cnt_q == CNT_W'(MEM_LAT - 1);
      case (state_q)
         IDLE: if (if_req | dm_req) begin
            // on a tie the data port wins unless it was the last one served
            dm_d    = dm_req & (~if_req | ~last_dm_q);
            addr_d  = dm_d ? dm_addr : if_addr;
            we_d    = dm_d & dm_we;
            wdata_d = dm_d ? dm_wdata : '0;
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (last_acc) begin
               state_d    = RESP;
               dm_rdata_d = dm_q & ~we_q ? mem_rdata : dm_rdata_q;
               if_rdata_d = dm_q ? if_rdata_q : mem_rdata[INSTR_W-1:0];
            end
         end
         RESP: begin
            last_dm_d = dm_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dm_q       <= 1'b0;
         last_dm_q  <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         dm_rdata_q <= '0;
         if_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dm_q       <= dm_d;
         last_dm_q  <= last_dm_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         dm_rdata_q <= dm_rdata_d;
         if_rdata_q <= if_rdata_d;
      end
   end
   assign mem_addr  = state_q == ACCESS ? addr_q : '0;
   assign mem_wdata = state_q == ACCESS ? wdata_q : '0;
   assign mem_we    = state_q == ACCESS && we_q && cnt_q == '0;
   assign if_ready  = state_q == RESP && !dm_q;
   assign dm_ready  = state_q == RESP && dm_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign stall_if  = if_req & ~if_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two lanes (MEM_LAT 1 and 3), each with a memory, a
// transaction-level reference model, directed checks and random traffic.
module tb_mem_port_arbiter;
   logic clk = 0;
   int   n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int lane, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s lane%0d: got %h expected %h", nm, lane, act, exp);
      end
   endtask
   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int L = g ? 3 : 1;
      logic        reset, if_req, if_ready, dm_req, dm_we, dm_ready, mem_we, stall_if;
      logic [5:0]  if_addr, dm_addr, mem_addr;
      logic [31:0] if_rdata;
      logic [63:0] dm_wdata, dm_rdata, mem_wdata, mem_rdata;
      logic [63:0] mem [64];
      logic [63:0] mmem [64];
      bit          busy = 0, who = 0, last_dm = 0, armed = 0, mem_ok = 0, la_we = 0, done = 0;
      int          k = 0;
      logic [5:0]  la = 0;
      logic [63:0] lw = 0, lr = 0, e_dm = 0;
      logic [31:0] e_if = 0;
      int          order[$];
      int          cnt;
      mem_port_arbiter #(.MEM_LAT(L)) dut (
         .clk(clk), .reset(reset),
         .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
         .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
         .dm_ready(dm_ready), .dm_rdata(dm_rdata),
         .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
         .stall_if(stall_if)
      );
      // read data is only valid in the final cycle of the address hold window
      assign mem_rdata = mem_ok ? mem[mem_addr] : ~mem[mem_addr];
      always @(negedge clk) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         mem_ok = busy && k == L;
      end
      always @(posedge clk) begin
         if (reset) begin
            busy = 0; last_dm = 0; e_if = 0; e_dm = 0; armed = 1;
         end else if (busy) begin
            if (k == L && who && !la_we) e_dm = lr;
            if (k == L && !who) e_if = lr[31:0];
            if (k == L + 1) begin
               busy = 0; last_dm = who;
            end else k++;
         end else if (if_req || dm_req) begin
            who   = dm_req && (!if_req || !last_dm);
            la    = who ? dm_addr : if_addr;
            la_we = who && dm_we;
            lw    = who ? dm_wdata : 64'd0;
            lr    = mmem[la];
            if (la_we) mmem[la] = lw;
            busy = 1; k = 1;
         end
      end
      always @(posedge clk) begin
         #1;
         if (armed) begin
            chk("if_ready", g, if_ready, busy && k == L + 1 && !who);
            chk("dm_ready", g, dm_ready, busy && k == L + 1 && who);
            chk("if_rdata", g, if_rdata, e_if);
            chk("dm_rdata", g, dm_rdata, e_dm);
            chk("mem_addr", g, mem_addr, busy && k <= L ? la : 6'd0);
            chk("mem_we", g, mem_we, busy && k == 1 && la_we);
            chk("mem_wdata", g, mem_wdata, busy && k <= L ? lw : 64'd0);
            chk("stall_if", g, stall_if, if_req && !(busy && k == L + 1 && !who));
            chk("one_ready", g, if_ready & dm_ready, 0);
         end
      end
      initial begin
         for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
         mem[3] = 64'h0000_0000_00A0_0093;
         mem[7] = 64'h0123_4567_89AB_CDEF;
         for (int i = 0; i < 64; i++) mmem[i] = mem[i];
         reset = 1; if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
         repeat (5) @(negedge clk);
         chk("rst_if_ready", g, if_ready, 0);
         chk("rst_dm_ready", g, dm_ready, 0);
         chk("rst_if_rdata", g, if_rdata, 0);
         chk("rst_dm_rdata", g, dm_rdata, 0);
         chk("rst_mem_addr", g, mem_addr, 0);
         chk("rst_mem_we", g, mem_we, 0);
         chk("rst_mem_wdata", g, mem_wdata, 0);
         chk("rst_stall", g, stall_if, 0);
         reset = 0;
         @(negedge clk);
         if_req = 1; if_addr = 3;
         #1 chk("t2_stall0", g, stall_if, 1);
         for (int n = 1; n <= L + 1; n++) begin
            @(negedge clk);
            chk("t2_mem_addr", g, mem_addr, n <= L ? 3 : 0);
            chk("t2_stall", g, stall_if, n <= L);
            chk("t2_if_ready", g, if_ready, n == L + 1);
         end
         chk("t2_if_rdata", g, if_rdata, 32'h00A0_0093);
         if_req = 0;
         @(negedge clk);
         if_req = 1; dm_req = 1; dm_we = 0; if_addr = 6'($urandom); dm_addr = 6'($urandom);
         for (int n = 0; n < 8 * (L + 2) && order.size() < 4; n++) begin
            @(negedge clk);
            if (dm_ready) order.push_back(1);
            if (if_ready) order.push_back(0);
         end
         if_req = 0; dm_req = 0;
         chk("t4_served", g, order.size(), 4);
         for (int i = 0; i < 4; i++) chk("t4_order", g, i < order.size() ? order[i] : 2, i % 2 == 0);
         @(negedge clk);
         dm_req = 1; dm_we = 1; dm_addr = 5; dm_wdata = 64'hDEAD_BEEF_0000_0001; cnt = 0;
         for (int n = 1; n <= L + 1; n++) begin
            @(negedge clk);
            cnt += mem_we;
         end
         chk("t3_store_ready", g, dm_ready, 1);
         chk("t3_we_cycles", g, cnt, 1);
         dm_req = 0; dm_we = 0;
         @(negedge clk);
         dm_req = 1; dm_addr = 5; dm_wdata = 0;
         repeat (L + 1) @(negedge clk);
         chk("t3_load_ready", g, dm_ready, 1);
         chk("t3_load_data", g, dm_rdata, 64'hDEAD_BEEF_0000_0001);
         dm_req = 0;
         @(negedge clk);
         dm_req = 1; dm_addr = 7;
         for (int n = 1; n <= L + 1; n++) begin
            @(negedge clk);
            chk("t5_mem_addr", g, mem_addr, n <= L ? 7 : 0);
            chk("t5_dm_ready", g, dm_ready, n == L + 1);
         end
         chk("t5_data", g, dm_rdata, 64'h0123_4567_89AB_CDEF);
         dm_req = 0;
         @(negedge clk);
         dm_req = 1; dm_we = 1; dm_addr = 9; dm_wdata = 64'hCAFE_F00D_1234_5678;
         repeat (L > 1 ? 2 : 1) @(negedge clk);
         reset = 1;
         @(negedge clk);
         cnt = dm_ready + mem_we;
         reset = 0; dm_req = 0; dm_we = 0;
         repeat (L + 3) begin
            @(negedge clk);
            cnt += dm_ready + mem_we;
         end
         chk("t6_quiet", g, cnt, 0);
         dm_req = 1; dm_addr = 9;
         repeat (L + 1) @(negedge clk);
         chk("t6_next_ready", g, dm_ready, 1);
         chk("t6_next_data", g, dm_rdata, 64'hCAFE_F00D_1234_5678);
         dm_req = 0;
         for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (if_ready || (if_req && $urandom_range(40) == 0)) if_req = 0;
            else if (!if_req) if_req = $urandom_range(2) == 0;
            if (dm_ready || (dm_req && $urandom_range(40) == 0)) dm_req = 0;
            else if (!dm_req) dm_req = $urandom_range(2) == 0;
            if_addr  = 6'($urandom);
            dm_addr  = 6'($urandom_range(15));
            dm_we    = 1'($urandom_range(1));
            dm_wdata = {$urandom, $urandom};
            reset    = $urandom_range(150) == 0;
         end
         @(negedge clk);
         if_req = 0; dm_req = 0; reset = 0;
         repeat (L + 4) @(negedge clk);
         done = 1;
      end
   end
   initial begin
      for (int t = 0; t < 60000 && !(lane[0].done && lane[1].done); t++) @(posedge clk);
      chk("finished", 0, {lane[1].done, lane[0].done}, 2'b11);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
